// File: rtl/uart_debug_unit.sv
// Host-side debug controller between the UART RX/TX pair and the MIPS pipeline:
// loads program words, runs or single-steps the pipeline, and streams latches/regs/memory back.
module uart_debug_unit #(
    parameter int                 NB_DATA    = 8,
    parameter int                 NB_WORD    = 32,
    parameter int                 NB_LATCH   = 400,
    parameter int                 N_REGS     = 32,
    parameter int                 N_MEM      = 32,
    parameter int                 IMEM_DEPTH = 256,
    parameter logic [NB_WORD-1:0] HALT_WORD  = 32'hFFFFFFFF
) (
    input  logic                      clk,
    input  logic                      i_rst_n,
    input  logic [NB_DATA-1:0]        i_rx_data,
    input  logic                      i_rx_done,
    input  logic                      i_tx_done,
    output logic                      o_tx_start,
    output logic [NB_DATA-1:0]        o_tx_data,
    input  logic                      i_end,
    input  logic [NB_LATCH-1:0]       i_latches,
    output logic [$clog2(N_REGS)-1:0] o_reg_addr,
    input  logic [NB_WORD-1:0]        i_reg_data,
    output logic [$clog2(N_MEM)-1:0]  o_mem_addr,
    input  logic [NB_WORD-1:0]        i_mem_data,
    output logic [NB_WORD-1:0]        o_instruction,
    output logic [NB_WORD-1:0]        o_instruction_address,
    output logic                      o_valid,
    output logic                      o_step,
    output logic                      o_start,
    output logic                      o_busy
);

    // state      | meaning
    // IDLE       | waiting for a host command
    // LOAD       | assembling program words from RX bytes, writing imem
    // CONT_RUN   | pipeline free-running until it retires HALT
    // DBG_WAIT   | debug session, waiting for STEP / END_DBG
    // DUMP_LATCH | sending the pipeline latch snapshot
    // DUMP_REG   | sending the register file, one word per register
    // DUMP_MEM   | sending data memory, one word per address
    // DONE       | dump finished; back to DBG_WAIT or IDLE
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CONT_RUN, S_DBG_WAIT,
        S_DUMP_LATCH, S_DUMP_REG, S_DUMP_MEM, S_DONE
    } state_t;

    // Sub-phase of every dump item: present address, capture, then per-byte send/wait.
    typedef enum logic [1:0] {PH_ADDR, PH_CAP, PH_SEND, PH_WAIT} phase_t;

    localparam int NB_RA       = $clog2(N_REGS);
    localparam int NB_MA       = $clog2(N_MEM);
    localparam int WORD_BYTES  = NB_WORD / NB_DATA;
    localparam int LATCH_BYTES = NB_LATCH / NB_DATA;
    localparam int NB_CNT      = $clog2(LATCH_BYTES + 1);
    localparam int NB_WB       = $clog2(WORD_BYTES + 1);
    localparam int NB_WCNT     = $clog2(IMEM_DEPTH + 1);

    localparam logic [NB_CNT-1:0]  LATCH_CNT    = NB_CNT'(LATCH_BYTES);
    localparam logic [NB_CNT-1:0]  WORD_CNT     = NB_CNT'(WORD_BYTES);
    localparam logic [NB_WB-1:0]   WORD_BYTES_W = NB_WB'(WORD_BYTES);
    localparam logic [NB_WCNT-1:0] DEPTH_W      = NB_WCNT'(IMEM_DEPTH);
    localparam logic [NB_WORD-1:0] ADDR_STEP    = NB_WORD'(NB_WORD / 8);
    localparam logic [NB_RA-1:0]   LAST_REG     = NB_RA'(N_REGS - 1);
    localparam logic [NB_MA-1:0]   LAST_MEM     = NB_MA'(N_MEM - 1);

    localparam logic [NB_DATA-1:0] CMD_LOAD  = NB_DATA'(8'h01);
    localparam logic [NB_DATA-1:0] CMD_DEBUG = NB_DATA'(8'h02);
    localparam logic [NB_DATA-1:0] CMD_CONT  = NB_DATA'(8'h04);
    localparam logic [NB_DATA-1:0] CMD_STEP  = NB_DATA'(8'h08);
    localparam logic [NB_DATA-1:0] CMD_END   = NB_DATA'(8'h10);

    state_t                    state_q;
    phase_t                    phase_q;
    logic                      debug_q;
    logic [NB_WORD-NB_DATA-1:0] word_q;
    logic [NB_WORD-1:0]        word_d;
    logic [NB_WB-1:0]          wbyte_q;
    logic [NB_WORD-1:0]        waddr_q;
    logic [NB_WCNT-1:0]        wcount_q;
    logic [NB_LATCH-1:0]       tx_buf_q;
    logic [NB_CNT-1:0]         bytes_left_q;
    logic [NB_RA-1:0]          reg_addr_q;
    logic [NB_MA-1:0]          mem_addr_q;
    logic                      tx_start_q;
    logic [NB_DATA-1:0]        tx_data_q;
    logic [NB_WORD-1:0]        instr_q;
    logic [NB_WORD-1:0]        iaddr_q;
    logic                      valid_q;
    logic                      step_q;
    logic                      start_q;

    assign word_d = {word_q, i_rx_data};

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            phase_q      <= PH_ADDR;
            debug_q      <= 1'b0;
            word_q       <= '0;
            wbyte_q      <= '0;
            waddr_q      <= '0;
            wcount_q     <= '0;
            tx_buf_q     <= '0;
            bytes_left_q <= '0;
            reg_addr_q   <= '0;
            mem_addr_q   <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            instr_q      <= '0;
            iaddr_q      <= '0;
            valid_q      <= 1'b0;
            step_q       <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            valid_q    <= 1'b0;
            step_q     <= 1'b0;
            tx_start_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DBG_WAIT: begin
                    if (i_rx_done) begin
                        case (i_rx_data)
                            CMD_LOAD: begin
                                state_q <= S_LOAD;
                                wbyte_q <= WORD_BYTES_W;
                                debug_q <= 1'b0;
                            end
                            CMD_DEBUG: begin
                                state_q <= S_DBG_WAIT;
                                debug_q <= 1'b1;
                            end
                            CMD_CONT: begin
                                state_q <= S_CONT_RUN;
                                start_q <= 1'b1;
                                debug_q <= 1'b0;
                            end
                            CMD_STEP: begin
                                if (state_q == S_DBG_WAIT) begin
                                    state_q <= S_DUMP_LATCH;
                                    phase_q <= PH_CAP;
                                    step_q  <= !i_end;
                                end
                            end
                            CMD_END: begin
                                if (state_q == S_DBG_WAIT) begin
                                    state_q <= S_DUMP_LATCH;
                                    phase_q <= PH_CAP;
                                    debug_q <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_LOAD: begin
                    if (i_rx_done) begin
                        word_q <= word_d[NB_WORD-NB_DATA-1:0];
                        if (wbyte_q == NB_WB'(1)) begin
                            wbyte_q <= WORD_BYTES_W;
                            // words beyond imem capacity are parsed but never written
                            if (wcount_q < DEPTH_W) begin
                                valid_q  <= 1'b1;
                                instr_q  <= word_d;
                                iaddr_q  <= waddr_q;
                                waddr_q  <= waddr_q + ADDR_STEP;
                                wcount_q <= wcount_q + NB_WCNT'(1);
                            end
                            if (word_d == HALT_WORD) begin
                                state_q  <= S_IDLE;
                                waddr_q  <= '0;
                                wcount_q <= '0;
                            end
                        end else begin
                            wbyte_q <= wbyte_q - NB_WB'(1);
                        end
                    end
                end
                S_CONT_RUN: begin
                    if (i_end) begin
                        start_q <= 1'b0;
                        state_q <= S_DUMP_LATCH;
                        phase_q <= PH_CAP;
                    end
                end
                S_DUMP_LATCH, S_DUMP_REG, S_DUMP_MEM: begin
                    case (phase_q)
                        PH_ADDR: phase_q <= PH_CAP;
                        PH_CAP: begin
                            phase_q <= PH_SEND;
                            case (state_q)
                                S_DUMP_LATCH: begin
                                    tx_buf_q     <= i_latches;
                                    bytes_left_q <= LATCH_CNT;
                                end
                                S_DUMP_REG: begin
                                    tx_buf_q     <= NB_LATCH'(i_reg_data) << (NB_LATCH - NB_WORD);
                                    bytes_left_q <= WORD_CNT;
                                end
                                default: begin
                                    tx_buf_q     <= NB_LATCH'(i_mem_data) << (NB_LATCH - NB_WORD);
                                    bytes_left_q <= WORD_CNT;
                                end
                            endcase
                        end
                        PH_SEND: begin
                            tx_data_q  <= tx_buf_q[NB_LATCH-1 -: NB_DATA];
                            tx_buf_q   <= tx_buf_q << NB_DATA;
                            tx_start_q <= 1'b1;
                            phase_q    <= PH_WAIT;
                        end
                        default: begin
                            if (i_tx_done) begin
                                if (bytes_left_q == NB_CNT'(1)) begin
                                    phase_q <= PH_ADDR;
                                    case (state_q)
                                        S_DUMP_LATCH: begin
                                            state_q    <= S_DUMP_REG;
                                            reg_addr_q <= '0;
                                        end
                                        S_DUMP_REG: begin
                                            if (reg_addr_q == LAST_REG) begin
                                                state_q    <= S_DUMP_MEM;
                                                mem_addr_q <= '0;
                                            end else begin
                                                reg_addr_q <= reg_addr_q + NB_RA'(1);
                                            end
                                        end
                                        default: begin
                                            if (mem_addr_q == LAST_MEM) begin
                                                state_q <= S_DONE;
                                            end else begin
                                                mem_addr_q <= mem_addr_q + NB_MA'(1);
                                            end
                                        end
                                    endcase
                                end else begin
                                    bytes_left_q <= bytes_left_q - NB_CNT'(1);
                                    phase_q      <= PH_SEND;
                                end
                            end
                        end
                    endcase
                end
                default: begin
                    if (debug_q && !i_end) begin
                        state_q <= S_DBG_WAIT;
                    end else begin
                        state_q <= S_IDLE;
                        debug_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign o_tx_start            = tx_start_q;
    assign o_tx_data             = tx_data_q;
    assign o_reg_addr            = reg_addr_q;
    assign o_mem_addr            = mem_addr_q;
    assign o_instruction         = instr_q;
    assign o_instruction_address = iaddr_q;
    assign o_valid               = valid_q;
    assign o_step                = step_q;
    assign o_start               = start_q;
    assign o_busy                = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_debug_unit.sv
// Bench for uart_debug_unit: directed command sequence with randomized payloads,
// expected load writes and dump byte streams computed from the command rules.
module tb_uart_debug_unit;
    localparam int NB_LATCH   = 400;
    localparam int N_REGS     = 32;
    localparam int N_MEM      = 32;
    localparam int IMEM_DEPTH = 256;
    localparam int DUMP_BYTES = NB_LATCH / 8 + 4 * N_REGS + 4 * N_MEM;

    logic                clk = 1'b0;
    logic                i_rst_n = 1'b0;
    logic [7:0]          i_rx_data = '0;
    logic                i_rx_done = 1'b0;
    logic                i_tx_done = 1'b0;
    logic                o_tx_start;
    logic [7:0]          o_tx_data;
    logic                i_end = 1'b0;
    logic [NB_LATCH-1:0] i_latches = '0;
    logic [4:0]          o_reg_addr;
    logic [31:0]         i_reg_data = '0;
    logic [4:0]          o_mem_addr;
    logic [31:0]         i_mem_data = '0;
    logic [31:0]         o_instruction;
    logic [31:0]         o_instruction_address;
    logic                o_valid;
    logic                o_step;
    logic                o_start;
    logic                o_busy;

    uart_debug_unit dut (
        .clk(clk), .i_rst_n(i_rst_n),
        .i_rx_data(i_rx_data), .i_rx_done(i_rx_done), .i_tx_done(i_tx_done),
        .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
        .i_end(i_end), .i_latches(i_latches),
        .o_reg_addr(o_reg_addr), .i_reg_data(i_reg_data),
        .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
        .o_instruction(o_instruction), .o_instruction_address(o_instruction_address),
        .o_valid(o_valid), .o_step(o_step), .o_start(o_start), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // register file and data memory with one-cycle synchronous read
    logic [31:0] regs [N_REGS];
    logic [31:0] mem  [N_MEM];
    always @(posedge clk) begin
        i_reg_data <= regs[o_reg_addr];
        i_mem_data <= mem[o_mem_addr];
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
    } wr_t;
    wr_t wr_q[$];
    int  step_cycles = 0;

    always @(negedge clk) begin
        wr_t w;
        if (o_valid) begin
            w.instr = o_instruction;
            w.addr  = o_instruction_address;
            wr_q.push_back(w);
        end
        if (o_step) step_cycles++;
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge clk);
        i_rx_done = 1'b0;
    endtask

    task automatic new_payload();
        for (int k = 0; k < NB_LATCH / 8; k++) i_latches[8*k +: 8] = 8'($urandom);
        for (int m = 0; m < N_MEM; m++) mem[m] = $urandom;
    endtask

    task automatic load_and_check(input string tag, input logic [31:0] words[$]);
        int base, exp_n, bad;
        base = wr_q.size();
        send_byte(8'h01);
        foreach (words[i]) for (int k = 3; k >= 0; k--) send_byte(words[i][8*k +: 8]);
        repeat (3) @(negedge clk);
        exp_n = (words.size() < IMEM_DEPTH) ? words.size() : IMEM_DEPTH;
        chk({tag, "_wr_count"}, 64'(wr_q.size() - base), 64'(exp_n));
        bad = 0;
        for (int i = 0; i < exp_n && base + i < wr_q.size(); i++)
            if (wr_q[base+i].instr !== words[i] || wr_q[base+i].addr !== 32'(4 * i)) bad++;
        chk({tag, "_wr_content"}, 64'(bad), 64'd0);
        if (wr_q.size() > base)
            chk({tag, "_last_addr"}, 64'(wr_q[$].addr), 64'(4 * (exp_n - 1)));
        chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    endtask

    // Collects one dump, answering each start with a delayed tx_done; abort_at>0 resets mid-stream.
    task automatic run_dump(input string tag, input int abort_at);
        logic [7:0] exp_b[$];
        logic [7:0] got_b[$];
        int idle, hs_err, hold_err, bad, d;
        for (int k = NB_LATCH / 8 - 1; k >= 0; k--) exp_b.push_back(i_latches[8*k +: 8]);
        for (int r = 0; r < N_REGS; r++) for (int k = 3; k >= 0; k--) exp_b.push_back(regs[r][8*k +: 8]);
        for (int m = 0; m < N_MEM; m++)  for (int k = 3; k >= 0; k--) exp_b.push_back(mem[m][8*k +: 8]);
        idle = 0; hs_err = 0; hold_err = 0;
        while (got_b.size() < DUMP_BYTES && idle < 200) begin
            @(negedge clk);
            if (!o_tx_start) begin
                idle++;
            end else begin
                idle = 0;
                got_b.push_back(o_tx_data);
                if (got_b.size() == abort_at) begin
                    i_rst_n = 1'b0;
                    #1;
                    chk({tag, "_rst_tx_start"}, 64'(o_tx_start), 64'd0);
                    chk({tag, "_rst_busy"}, 64'(o_busy), 64'd0);
                    chk({tag, "_rst_tx_data"}, 64'(o_tx_data), 64'd0);
                    @(negedge clk);
                    i_rst_n = 1'b1;
                    return;
                end
                d = $urandom_range(2, 5);
                for (int j = 0; j < d; j++) begin
                    @(negedge clk);
                    if (o_tx_start) hs_err++;
                    if (o_tx_data !== got_b[$]) hold_err++;
                    if (got_b.size() == 5) begin
                        i_rx_data = 8'h10;
                        i_rx_done = (j == 0);
                    end
                end
                i_tx_done = 1'b1;
                @(negedge clk);
                i_tx_done = 1'b0;
                if (o_tx_start) hs_err++;
            end
        end
        chk({tag, "_byte_count"}, 64'(got_b.size()), 64'(DUMP_BYTES));
        chk({tag, "_handshake"}, 64'(hs_err), 64'd0);
        chk({tag, "_data_hold"}, 64'(hold_err), 64'd0);
        bad = 0;
        for (int i = 0; i < got_b.size() && i < DUMP_BYTES; i++) if (got_b[i] !== exp_b[i]) bad++;
        chk({tag, "_bytes"}, 64'(bad), 64'd0);
    endtask

    initial begin
        logic [31:0] words[$];
        int sc, low;
        for (int r = 0; r < N_REGS; r++) regs[r] = 32'(r);
        new_payload();
        repeat (3) @(negedge clk);
        chk("rst_tx_start", 64'(o_tx_start), 64'd0);
        chk("rst_tx_data", 64'(o_tx_data), 64'd0);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_instr", 64'(o_instruction), 64'd0);
        chk("rst_iaddr", 64'(o_instruction_address), 64'd0);
        chk("rst_step_start", 64'({o_step, o_start}), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_addrs", 64'({o_reg_addr, o_mem_addr}), 64'd0);
        i_rst_n = 1'b1;
        @(negedge clk);

        // unknown and debug-only commands are ignored in IDLE
        send_byte(8'h55);
        send_byte(8'h08);
        send_byte(8'h10);
        repeat (2) @(negedge clk);
        chk("idle_ignore_busy", 64'(o_busy), 64'd0);
        chk("idle_ignore_step", 64'(step_cycles), 64'd0);

        words = '{32'h12345678, 32'h9ABCDEF0, 32'hFFFFFFFF};
        load_and_check("load3", words);

        words = {};
        for (int i = 0; i < IMEM_DEPTH + 1; i++) words.push_back($urandom & 32'h7FFFFFFF);
        words.push_back(32'hFFFFFFFF);
        load_and_check("load_full", words);

        new_payload();
        send_byte(8'h04);
        chk("cont_start", 64'(o_start), 64'd1);
        chk("cont_busy", 64'(o_busy), 64'd1);
        low = 0;
        repeat (50) begin
            @(negedge clk);
            if (!o_start) low++;
        end
        chk("cont_start_held", 64'(low), 64'd0);
        i_end = 1'b1;
        @(negedge clk);
        chk("cont_start_drop", 64'(o_start), 64'd0);
        run_dump("cont", -1);
        repeat (3) @(negedge clk);
        chk("cont_idle", 64'(o_busy), 64'd0);
        i_end = 1'b0;

        send_byte(8'h02);
        chk("dbg_busy", 64'(o_busy), 64'd1);
        chk("dbg_start", 64'(o_start), 64'd0);
        for (int s = 0; s < 2; s++) begin
            new_payload();
            sc = step_cycles;
            send_byte(8'h08);
            run_dump($sformatf("step%0d", s), -1);
            repeat (3) @(negedge clk);
            chk($sformatf("step%0d_pulse", s), 64'(step_cycles - sc), 64'd1);
            chk($sformatf("step%0d_dbg_wait", s), 64'(o_busy), 64'd1);
        end
        new_payload();
        sc = step_cycles;
        send_byte(8'h10);
        run_dump("end_dbg", -1);
        repeat (3) @(negedge clk);
        chk("end_dbg_no_step", 64'(step_cycles - sc), 64'd0);
        chk("end_dbg_idle", 64'(o_busy), 64'd0);

        // STEP after the program has ended: dump without a step pulse, then IDLE
        send_byte(8'h02);
        i_end = 1'b1;
        new_payload();
        sc = step_cycles;
        send_byte(8'h08);
        run_dump("step_ended", -1);
        repeat (3) @(negedge clk);
        chk("step_ended_no_step", 64'(step_cycles - sc), 64'd0);
        chk("step_ended_idle", 64'(o_busy), 64'd0);
        i_end = 1'b0;

        new_payload();
        send_byte(8'h04);
        repeat (5) @(negedge clk);
        i_end = 1'b1;
        run_dump("abort", 53);
        @(negedge clk);
        chk("abort_idle", 64'(o_busy), 64'd0);
        chk("abort_start", 64'(o_start), 64'd0);
        i_end = 1'b0;

        new_payload();
        send_byte(8'h04);
        repeat (10) @(negedge clk);
        i_end = 1'b1;
        run_dump("after_rst", -1);
        repeat (3) @(negedge clk);
        chk("after_rst_idle", 64'(o_busy), 64'd0);
        i_end = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
